// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//   Two-master round-robin arbiter for the native picorv32 memory bus.
//   Master 0 is the CPU and master 1 is a secondary master such as a DMA or a
//   debug loader. Both share one slave bus that feeds the ROM/RAM/LED/UART
//   decode. A grant is held until the slave answers with ready. The arbiter
//   always passes through IDLE between transfers, so s_valid drops for at
//   least one cycle between back-to-back transfers.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a 16-bit counter runs while a grant is held. If the slave
//   has not answered after TIMEOUT_CYCLES cycles, the owner receives a forced
//   ready with ABORT_RDATA, s_valid is dropped in that cycle, and the sticky
//   err flag is set. err_addr keeps the address of the first aborted transfer.
//   When undefined, a grant waits for the slave indefinitely and
//   o_err / o_err_addr are constant zero.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles a grant may wait for i_s_ready (1..65535)
//   ABORT_RDATA     read data returned on an aborted transfer
//
// Ports:
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_mX_valid/instr/addr/wdata/wstrb   master X request (wstrb 0 = read)
//   o_mX_ready/rdata                    master X response
//   o_s_valid/instr/addr/wdata/wstrb    request to the slave decode
//   i_s_ready/rdata                     slave response
//   o_grant                 one-hot owner (bit0 = m0, bit1 = m1), 00 when idle
//   o_err                   sticky abort flag
//   o_err_addr              address of the first aborted transfer
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ABORT_RDATA    = 32'hDEAD_BEEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_valid,
  input  logic        i_m0_instr,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [3:0]  i_m0_wstrb,
  output logic        o_m0_ready,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_valid,
  input  logic        i_m1_instr,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_wstrb,
  output logic        o_m1_ready,
  output logic [31:0] o_m1_rdata,
  output logic        o_s_valid,
  output logic        o_s_instr,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_wdata,
  output logic [3:0]  o_s_wstrb,
  input  logic        i_s_ready,
  input  logic [31:0] i_s_rdata,
  output logic [1:0]  o_grant,
  output logic        o_err,
  output logic [31:0] o_err_addr
);

  // Reject an out-of-range timeout at elaboration time.
  if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;        // owner of the most recently completed grant
  logic        w_last_nxt;
  logic        w_granted;
  logic        w_own_idx;     // 0 = m0 owns the bus, 1 = m1
  logic        w_abort;       // timeout abort in the current cycle
  logic        w_own_valid;
  logic        w_own_instr;
  logic [31:0] w_own_addr;
  logic [31:0] w_own_wdata;
  logic [3:0]  w_own_wstrb;
  logic        w_rsp_ready;
  logic [31:0] w_rsp_rdata;

  assign w_granted = (r_state == ST_GNT0) || (r_state == ST_GNT1);
  assign w_own_idx = (r_state == ST_GNT1);

  // Request fields of the current owner (m0 when idle; masked later).
  always_comb begin
    if (w_own_idx) begin
      w_own_valid = i_m1_valid;
      w_own_instr = i_m1_instr;
      w_own_addr  = i_m1_addr;
      w_own_wdata = i_m1_wdata;
      w_own_wstrb = i_m1_wstrb;
    end else begin
      w_own_valid = i_m0_valid;
      w_own_instr = i_m0_instr;
      w_own_addr  = i_m0_addr;
      w_own_wdata = i_m0_wdata;
      w_own_wstrb = i_m0_wstrb;
    end
  end

  // An abort substitutes for the slave response for exactly one cycle.
  assign w_rsp_ready = i_s_ready || w_abort;
  assign w_rsp_rdata = w_abort ? ABORT_RDATA : i_s_rdata;

  // State and round-robin history register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;   // m0 wins the first tie
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state: arbitration in IDLE, release on ready, abort or dropped valid.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (i_m0_valid && i_m1_valid) begin
          w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
        end else if (i_m0_valid) begin
          w_state_nxt = ST_GNT0;
        end else if (i_m1_valid) begin
          w_state_nxt = ST_GNT1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (i_s_ready || w_abort) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = w_own_idx;
        end else if (!w_own_valid) begin
          // Owner withdrew without a response: release, history unchanged.
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output steering: owner drives the slave bus, slave response goes back.
  always_comb begin
    o_s_valid  = 1'b0;
    o_s_instr  = 1'b0;
    o_s_addr   = 32'h0000_0000;
    o_s_wdata  = 32'h0000_0000;
    o_s_wstrb  = 4'b0000;
    o_m0_ready = 1'b0;
    o_m0_rdata = 32'h0000_0000;
    o_m1_ready = 1'b0;
    o_m1_rdata = 32'h0000_0000;
    o_grant    = 2'b00;
    if (w_granted) begin
      o_s_valid = w_own_valid && !w_abort;
      o_s_instr = w_own_instr;
      o_s_addr  = w_own_addr;
      o_s_wdata = w_own_wdata;
      o_s_wstrb = w_own_wstrb;
      if (w_own_idx) begin
        o_grant    = 2'b10;
        o_m1_ready = w_rsp_ready;
        o_m1_rdata = w_rsp_rdata;
      end else begin
        o_grant    = 2'b01;
        o_m0_ready = w_rsp_ready;
        o_m0_rdata = w_rsp_rdata;
      end
    end else begin
      o_grant = 2'b00;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_to_cnt;
  logic        r_err;
  logic [31:0] r_err_addr;

  assign w_abort = w_granted && !i_s_ready && (r_to_cnt == LP_TO_LIMIT);

  // Timeout counter (zero while idle, so every grant starts from 0) and
  // sticky error capture of the first aborted address.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt   <= 16'd0;
      r_err      <= 1'b0;
      r_err_addr <= 32'h0000_0000;
    end else begin
      if (!w_granted) begin
        r_to_cnt <= 16'd0;
      end else if (!i_s_ready) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end else begin
        r_to_cnt <= r_to_cnt;
      end
      if (w_abort) begin
        r_err <= 1'b1;
        if (!r_err) begin
          r_err_addr <= w_own_addr;
        end else begin
          r_err_addr <= r_err_addr;
        end
      end else begin
        r_err      <= r_err;
        r_err_addr <= r_err_addr;
      end
    end
  end

  assign o_err      = r_err;
  assign o_err_addr = r_err_addr;
`else
  assign w_abort    = 1'b0;
  assign o_err      = 1'b0;
  assign o_err_addr = 32'h0000_0000;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the native picorv32 memory bus. Master 0 is the CPU and master 1 is a secondary bus master such as a DMA or debug loader. The block multiplexes both onto the single shared slave bus that feeds the ROM, RAM, LED and UART decode. It grants round-robin, holds each grant until the slave returns `ready`, and optionally aborts transfers that exceed a timeout.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles a granted transfer may wait for `s_ready` before it is aborted (used only with `ARB_TIMEOUT_EN`); legal range 1..65535.
- `ABORT_RDATA`, default 32'hDEAD_BEEF: read data returned on an aborted transfer.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m0_valid`, `m0_instr`  in  1 each  master 0 request.
- `m0_addr`, `m0_wdata`  in  32 each.
- `m0_wstrb`  in  4  write strobes; 0 means read.
- `m0_ready`  out  1 / `m0_rdata`  out  32  master 0 response.
- `m1_*`  same set of signals and widths for master 1.
- `s_valid`, `s_instr`  out  1 each  to the slave decode.
- `s_addr`, `s_wdata`  out  32 each.
- `s_wstrb`  out  4.
- `s_ready`  in  1 / `s_rdata`  in  32  slave response.
- `grant`  out  2  one-hot current owner; 00 when idle.
- `err`  out  1  sticky abort flag.
- `err_addr`  out  32  address of the first aborted transfer.

## Operation

- FSM states: IDLE, GNT0, GNT1.
- **IDLE**
  - Only m0 valid → GNT0. Only m1 valid → GNT1.
  - Both valid → grant the master that did not own the most recent grant (`last` register).
  - Neither valid → stay in IDLE.
- **GNTx** (owner x)
  - `s_*` equals `mx_*`; `s_valid` = `mx_valid`.
  - `mx_ready` = `s_ready`; `mx_rdata` = `s_rdata`.
  - The non-owner sees `ready`=0 and `rdata`=0.
- **Leaving GNTx**
  - On `s_ready`=1: go to IDLE and set `last` := x.
  - If the owner drops `mx_valid` without `s_ready` (protocol violation): go to IDLE, `last` unchanged, no error.
- **IDLE outputs**: `s_valid`=0, `s_wstrb`=0, all `mx_ready`=0.
- **Reset values**: state IDLE, `last`=1 (so m0 wins the first tie), `grant`=00, `s_valid`=0, `s_addr`/`s_wdata`/`s_instr`=0, `err`=0, `err_addr`=0, timeout counter 0.
- **Reset mid-transfer**: `s_valid` is low the cycle after `rst` is sampled. The outstanding transfer is discarded and no ready is given to the master.

## Timing

- Grant latency: request valid at edge N (in IDLE) → `grant` and `s_valid` high at N+1.
- `s_ready` and `s_rdata` pass through to the owner combinationally, with zero added latency.
- After the `s_ready` cycle the state is IDLE for at least one cycle.
  - This guarantees `s_valid` is low for one cycle between transfers, which the registered slave-ready logic (valid && !ready) requires.
  - Minimum transfer period is therefore 3 cycles from request to next grant.
- Simultaneous events:
  - Both request in IDLE → exactly one grant.
  - The loser keeps `valid` high and is granted immediately after the next IDLE cycle.
  - Fairness bound: a continuously requesting master waits at most one foreign transfer.
- A request arriving in the same cycle as `s_ready` for the other master is evaluated in the following IDLE cycle.

## Configuration

- Macro `ARB_TIMEOUT_EN`, defined: a 16-bit counter runs in GNTx.
  - It clears on grant entry and increments each cycle `s_ready`=0.
  - On reaching `TIMEOUT_CYCLES`, the arbiter forces `mx_ready`=1 and `mx_rdata`=`ABORT_RDATA` for one cycle and drops `s_valid` in that cycle.
  - It then goes to IDLE.
  - `err` is set (sticky until `rst`); `err_addr` latches `s_addr` only if `err` was 0.
- Macro not defined: no counter. A granted transfer waits for `s_ready` indefinitely; `err`=0 and `err_addr`=0 constantly.

## Test plan

- Reset → `grant`=00, `s_valid`=0, `err`=0. Then m0 reads 0x0000_0004 and the slave gives ready one cycle after `s_valid` with rdata 0x1234_5678 → `m0_rdata`=0x1234_5678, `m1_ready` never 1.
- m0 and m1 assert valid in the same cycle after reset → m0 granted first. m1 is granted at the first GNT state after one IDLE cycle, and m0 is not regranted in between despite holding `valid`.
- Both masters request continuously for 8 transfers → grants alternate 0,1,0,1…; `s_valid` low for exactly one cycle between each.
- m1 write 0x0200_0000, wstrb 4'b0001, data 0xA5 → `s_wstrb`=0001, `s_wdata`=0xA5, `s_addr`=0x0200_0000; m0 outputs untouched.
- `rst` pulsed while GNT1 is waiting on the slave → next cycle IDLE, `s_valid`=0, no `m1_ready` pulse; a subsequent tie grants m0.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, m0 reads unmapped 0x3000_0000 and the slave never readies → `m0_ready` pulses 4 cycles after grant with rdata 0xDEAD_BEEF, `err`=1, `err_addr`=0x3000_0000. A second timeout leaves `err_addr` unchanged.
